// File: rtl/file_sink_pkg.sv
// Shared types and default geometry for the LZW capture sink and its file ROM counterpart.
package file_sink_pkg;

  localparam int ADDR_WIDTH_D = 12;
  localparam int DATA_WIDTH_D = 64;
  localparam int DEPTH_D      = 4096;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2,
    ERROR   = 2'd3
  } state_e;

endpackage

// File: rtl/file_sink_if.sv
// Capture stream, control/status and readback bundle between the LZW datapath and file_sink.
interface file_sink_if #(
  parameter int ADDR_WIDTH = file_sink_pkg::ADDR_WIDTH_D,
  parameter int DATA_WIDTH = file_sink_pkg::DATA_WIDTH_D
);

  logic                  start;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  valid;
  logic                  eof;
  logic                  ready;
  logic                  busy;
  logic                  done;
  logic                  overflow;
  logic [ADDR_WIDTH:0]   count;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;

  modport master (
    output start, data_in, valid, eof, rd_en, rd_addr,
    input  ready, busy, done, overflow, count, rd_data, rd_valid
  );

  modport slave (
    input  start, data_in, valid, eof, rd_en, rd_addr,
    output ready, busy, done, overflow, count, rd_data, rd_valid
  );

endinterface

// File: rtl/file_sink_ram.sv
// Simple dual-port RAM: one write port, one registered read-first read port (1-cycle latency).
// No reset and no backpressure so it maps onto block RAM.
module sink_ram #(
  parameter int ADDR_WIDTH = file_sink_pkg::ADDR_WIDTH_D,
  parameter int DATA_WIDTH = file_sink_pkg::DATA_WIDTH_D,
  parameter int DEPTH      = file_sink_pkg::DEPTH_D
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

  // Non-blocking read and write on the same edge give read-first behaviour.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/file_sink.sv
// Capture sink: stores code words until eof, counts them, flags overflow; readback latency 1 cycle.
// ready = capturing and not full, independent of valid; words offered while full are dropped.
module file_sink
  import file_sink_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_D,
  parameter int DATA_WIDTH = DATA_WIDTH_D,
  parameter int DEPTH      = DEPTH_D
) (
  input  logic       clk,
  input  logic       rst_n,
  file_sink_if.slave bus
);

  localparam logic [ADDR_WIDTH:0] FULL = (ADDR_WIDTH+1)'(DEPTH);

  state_e                state, state_nxt;
  logic [ADDR_WIDTH:0]   count;
  logic                  ready;
  logic                  wr_en;
  logic                  busy, done, overflow;
  logic [DATA_WIDTH-1:0] ram_q;
  logic                  rd_valid_q;
  logic                  rd_zero_q;

  assign ready = (state == CAPTURE) && (count < FULL);
  // A start pulse restarts the capture, so any word offered alongside it is dropped.
  assign wr_en = bus.valid && ready && !bus.start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    overflow  = 1'b0;
    case (state)
      IDLE, DONE, ERROR: begin
        if (bus.start) state_nxt = CAPTURE;
      end
      CAPTURE: begin
        // eof beats overflow when the RAM is full.
        if (bus.start)                        state_nxt = CAPTURE;
        else if (bus.eof)                     state_nxt = DONE;
        else if (bus.valid && (count == FULL)) state_nxt = ERROR;
      end
      default: state_nxt = IDLE;
    endcase
    busy     = (state == CAPTURE);
    done     = (state == DONE);
    overflow = (state == ERROR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         count <= '0;
    else if (bus.start) count <= '0;
    else if (wr_en)     count <= count + 1'b1;
  end

  // Addresses at or beyond count read as zero; the flag is captured with the read request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_q <= 1'b0;
      rd_zero_q  <= 1'b1;
    end else begin
      rd_valid_q <= bus.rd_en;
      if (bus.rd_en) rd_zero_q <= ({1'b0, bus.rd_addr} >= count);
    end
  end

  sink_ram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (count[ADDR_WIDTH-1:0]),
    .wdata (bus.data_in),
    .re    (bus.rd_en),
    .raddr (bus.rd_addr),
    .rdata (ram_q)
  );

  assign bus.ready    = ready;
  assign bus.busy     = busy;
  assign bus.done     = done;
  assign bus.overflow = overflow;
  assign bus.count    = count;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = rd_zero_q ? '0 : ram_q;

endmodule

// File: tb/tb_file_sink.sv
// Bench for file_sink: full-size instance for capture/readback, DEPTH=4 instance for overflow.
module tb_file_sink;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic [63:0] exp_q [$];
  logic [63:0] e;

  file_sink_if #(.ADDR_WIDTH(12), .DATA_WIDTH(64)) bi ();
  file_sink_if #(.ADDR_WIDTH(2),  .DATA_WIDTH(64)) b4 ();

  file_sink #(.ADDR_WIDTH(12), .DATA_WIDTH(64), .DEPTH(4096)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bi)
  );

  file_sink #(.ADDR_WIDTH(2), .DATA_WIDTH(64), .DEPTH(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bi.start = 0; bi.valid = 0; bi.eof = 0; bi.data_in = '0; bi.rd_en = 0; bi.rd_addr = '0;
    b4.start = 0; b4.valid = 0; b4.eof = 0; b4.data_in = '0; b4.rd_en = 0; b4.rd_addr = '0;
  endtask

  task automatic rd_main(input logic [11:0] a, input logic [63:0] ex);
    exp_q.push_back(ex);
    bi.rd_en = 1; bi.rd_addr = a;
    step();
    bi.rd_en = 0;
  endtask

  task automatic rd_small(input logic [1:0] a, input logic [63:0] ex);
    exp_q.push_back(ex);
    b4.rd_en = 1; b4.rd_addr = a;
    step();
    b4.rd_en = 0;
  endtask

  task automatic send_main(input logic [63:0] w);
    bi.valid = 1; bi.data_in = w;
    step();
    bi.valid = 0;
  endtask

  task automatic test_reset();
    checks++;
    if ({bi.count, bi.busy, bi.done, bi.overflow, bi.ready, bi.rd_valid} !== 18'd0) begin
      errors++;
      $display("FAIL reset_status count=%0d busy=%b done=%b ovf=%b ready=%b rv=%b want all 0",
               bi.count, bi.busy, bi.done, bi.overflow, bi.ready, bi.rd_valid);
    end
    checks++;
    if (bi.rd_data !== 64'd0) begin
      errors++; $display("FAIL reset_rd_data got=%h want=0", bi.rd_data);
    end
  endtask

  task automatic test_sequence();
    logic [63:0] w [11];
    w = '{65, 66, 66, 65, 66, 66, 66, 65, 66, 66, 65};
    bi.start = 1; step(); bi.start = 0;
    checks++;
    if (bi.busy !== 1'b1 || bi.ready !== 1'b1) begin
      errors++; $display("FAIL seq_armed busy=%b ready=%b want 1 1", bi.busy, bi.ready);
    end
    for (int i = 0; i < 11; i++) begin
      bi.valid = 1; bi.data_in = w[i];
      step();
    end
    bi.valid = 0; bi.eof = 1; step(); bi.eof = 0;
    checks++;
    if (bi.count !== 13'd11 || bi.done !== 1'b1 || bi.busy !== 1'b0 || bi.overflow !== 1'b0) begin
      errors++;
      $display("FAIL seq_status count=%0d done=%b busy=%b ovf=%b want 11 1 0 0",
               bi.count, bi.done, bi.busy, bi.overflow);
    end
    for (int i = 0; i < 12; i++) begin
      rd_main(12'(i), (i < 11) ? w[i] : 64'd0);
      e = exp_q.pop_front();
      checks++;
      if (bi.rd_valid !== 1'b1 || bi.rd_data !== e) begin
        errors++; $display("FAIL seq_rd[%0d] valid=%b got=%h want=%h", i, bi.rd_valid, bi.rd_data, e);
      end
    end
    step();
    checks++;
    if (bi.rd_valid !== 1'b0) begin
      errors++; $display("FAIL rd_valid_pulse got=%b want 0", bi.rd_valid);
    end
  endtask

  task automatic test_eof_with_word();
    bi.start = 1; step(); bi.start = 0;
    bi.valid = 1; bi.eof = 1; bi.data_in = 64'h1234;
    step();
    bi.valid = 0; bi.eof = 0;
    checks++;
    if (bi.count !== 13'd1 || bi.done !== 1'b1 || bi.ready !== 1'b0 || bi.busy !== 1'b0) begin
      errors++;
      $display("FAIL eof_word count=%0d done=%b ready=%b busy=%b want 1 1 0 0",
               bi.count, bi.done, bi.ready, bi.busy);
    end
    rd_main(12'd0, 64'h1234);
    e = exp_q.pop_front();
    checks++;
    if (bi.rd_valid !== 1'b1 || bi.rd_data !== e) begin
      errors++; $display("FAIL eof_word_rd valid=%b got=%h want=%h", bi.rd_valid, bi.rd_data, e);
    end
  endtask

  task automatic test_overflow();
    b4.start = 1; step(); b4.start = 0;
    for (int i = 0; i < 4; i++) begin
      b4.valid = 1; b4.data_in = 64'h100 + 64'(i);
      step();
    end
    checks++;
    if (b4.ready !== 1'b0 || b4.count !== 3'd4 || b4.busy !== 1'b1) begin
      errors++; $display("FAIL full_ready ready=%b count=%0d busy=%b want 0 4 1", b4.ready, b4.count, b4.busy);
    end
    b4.data_in = 64'h1FF; step(); b4.valid = 0;
    checks++;
    if (b4.overflow !== 1'b1 || b4.busy !== 1'b0 || b4.count !== 3'd4) begin
      errors++; $display("FAIL ovf_set ovf=%b busy=%b count=%0d want 1 0 4", b4.overflow, b4.busy, b4.count);
    end
    step();
    checks++;
    if (b4.overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_sticky got=%b want 1", b4.overflow);
    end
    for (int i = 0; i < 4; i++) begin
      rd_small(2'(i), 64'h100 + 64'(i));
      e = exp_q.pop_front();
      checks++;
      if (b4.rd_valid !== 1'b1 || b4.rd_data !== e) begin
        errors++; $display("FAIL ovf_rd[%0d] valid=%b got=%h want=%h", i, b4.rd_valid, b4.rd_data, e);
      end
    end
    b4.start = 1; step(); b4.start = 0;
    checks++;
    if (b4.overflow !== 1'b0 || b4.count !== 3'd0 || b4.busy !== 1'b1) begin
      errors++; $display("FAIL ovf_clear ovf=%b count=%0d busy=%b want 0 0 1", b4.overflow, b4.count, b4.busy);
    end
    for (int i = 0; i < 4; i++) begin
      b4.valid = 1; b4.data_in = 64'h200 + 64'(i);
      step();
    end
    b4.eof = 1; b4.data_in = 64'h2FF; step();
    b4.valid = 0; b4.eof = 0;
    checks++;
    if (b4.done !== 1'b1 || b4.overflow !== 1'b0 || b4.count !== 3'd4) begin
      errors++; $display("FAIL full_eof done=%b ovf=%b count=%0d want 1 0 4", b4.done, b4.overflow, b4.count);
    end
  endtask

  task automatic test_idle_ignore_and_reset();
    rst_n = 0; step(); rst_n = 1; step();
    bi.valid = 1; bi.eof = 1; bi.data_in = 64'hDEAD;
    step();
    checks++;
    if (bi.ready !== 1'b0) begin
      errors++; $display("FAIL idle_ready got=%b want 0", bi.ready);
    end
    step();
    bi.valid = 0; bi.eof = 0;
    checks++;
    if (bi.count !== 13'd0 || bi.busy !== 1'b0 || bi.done !== 1'b0) begin
      errors++; $display("FAIL idle_ignore count=%0d busy=%b done=%b want 0 0 0", bi.count, bi.busy, bi.done);
    end
    bi.start = 1; step(); bi.start = 0;
    for (int i = 0; i < 5; i++) send_main(64'h50 + 64'(i));
    checks++;
    if (bi.count !== 13'd5) begin
      errors++; $display("FAIL pre_reset_count got=%0d want 5", bi.count);
    end
    bi.rd_en = 1; bi.rd_addr = 12'd0;
    step();
    checks++;
    if (bi.rd_valid !== 1'b1) begin
      errors++; $display("FAIL pre_reset_rd_valid got=%b want 1", bi.rd_valid);
    end
    #2 rst_n = 0;
    #1;
    checks++;
    if ({bi.count, bi.busy, bi.ready, bi.rd_valid} !== 16'd0 || bi.rd_data !== 64'd0) begin
      errors++;
      $display("FAIL async_reset count=%0d busy=%b ready=%b rv=%b data=%h want all 0",
               bi.count, bi.busy, bi.ready, bi.rd_valid, bi.rd_data);
    end
    bi.rd_en = 0;
    #2 rst_n = 1;
    step();
  endtask

  task automatic test_read_during_write();
    bi.start = 1; step(); bi.start = 0;
    send_main(64'h5); send_main(64'h6); send_main(64'h0);
    bi.eof = 1; step(); bi.eof = 0;
    bi.start = 1; step(); bi.start = 0;
    send_main(64'h11); send_main(64'h22);
    exp_q.push_back(64'h0);
    bi.valid = 1; bi.data_in = 64'hAA; bi.rd_en = 1; bi.rd_addr = 12'd2;
    step();
    bi.valid = 0; bi.rd_en = 0;
    e = exp_q.pop_front();
    checks++;
    if (bi.rd_valid !== 1'b1 || bi.rd_data !== e) begin
      errors++; $display("FAIL rdw_same valid=%b got=%h want=%h", bi.rd_valid, bi.rd_data, e);
    end
    rd_main(12'd2, 64'hAA);
    e = exp_q.pop_front();
    checks++;
    if (bi.rd_valid !== 1'b1 || bi.rd_data !== e || bi.count !== 13'd3) begin
      errors++; $display("FAIL rdw_after valid=%b got=%h want=%h count=%0d", bi.rd_valid, bi.rd_data, e, bi.count);
    end
    bi.eof = 1; step(); bi.eof = 0;
  endtask

  task automatic test_back_to_back();
    bi.start = 1; step(); bi.start = 0;
    send_main(64'h31); send_main(64'h32);
    bi.start = 1; step(); bi.start = 0;
    checks++;
    if (bi.count !== 13'd0 || bi.busy !== 1'b1) begin
      errors++; $display("FAIL restart count=%0d busy=%b want 0 1", bi.count, bi.busy);
    end
    send_main(64'h31); send_main(64'h32); send_main(64'h33);
    bi.eof = 1; step(); bi.eof = 0;
    bi.start = 1; step(); bi.start = 0;
    send_main(64'd7); send_main(64'd8);
    bi.eof = 1; step(); bi.eof = 0;
    checks++;
    if (bi.count !== 13'd2 || bi.done !== 1'b1) begin
      errors++; $display("FAIL second_capture count=%0d done=%b want 2 1", bi.count, bi.done);
    end
    rd_main(12'd0, 64'd7);
    e = exp_q.pop_front();
    checks++;
    if (bi.rd_data !== e) begin
      errors++; $display("FAIL b2b_rd0 got=%h want=%h", bi.rd_data, e);
    end
    rd_main(12'd1, 64'd8);
    e = exp_q.pop_front();
    checks++;
    if (bi.rd_data !== e) begin
      errors++; $display("FAIL b2b_rd1 got=%h want=%h", bi.rd_data, e);
    end
    rd_main(12'd2, 64'd0);
    e = exp_q.pop_front();
    checks++;
    if (bi.rd_valid !== 1'b1 || bi.rd_data !== e) begin
      errors++; $display("FAIL b2b_rd2 valid=%b got=%h want=%h", bi.rd_valid, bi.rd_data, e);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 0;
    drive_idle();
    step();
    step();
    test_reset();
    rst_n = 1;
    step();
    test_sequence();
    test_eof_with_word();
    test_overflow();
    test_idle_ignore_and_reset();
    test_read_during_write();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/file_sink.md
Name: file_sink

Overview:
- Capture endpoint at the output end of the LZW datapath; counterpart to the input file ROM.
- Accepts compressed code words on a valid/ready handshake and stores them in an internal RAM until end-of-file.
- Counts captured words, flags overflow, and provides a registered readback port for bench checking and host upload.

Parameters:
ADDR_WIDTH, 12, RAM address width
DATA_WIDTH, 64, code word width
DEPTH, 4096, RAM entries; must be ≤ 2**ADDR_WIDTH

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse; arms a new capture
data_in  input  DATA_WIDTH  code word from compressor
valid  input  1  data_in holds a word
eof  input  1  end-of-file marker from upstream
ready  output  1  sink can accept a word this cycle
busy  output  1  capture in progress
done  output  1  eof received, capture closed
overflow  output  1  word offered while RAM full (sticky)
count  output  ADDR_WIDTH+1  number of words stored
rd_en  input  1  readback request
rd_addr  input  ADDR_WIDTH  readback address
rd_data  output  DATA_WIDTH  readback data
rd_valid  output  1  rd_data valid

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous, active-low (rst_n).
- Reset values: state=IDLE, count=0, done=0, overflow=0, busy=0, rd_valid=0, rd_data=0. RAM contents are not cleared.
- FSM states:
  - IDLE: after reset; ready=0.
  - CAPTURE: busy=1.
  - DONE: done=1.
  - ERROR: overflow=1.
- Transitions:
  - IDLE/DONE/ERROR --start--> CAPTURE. This clears count, done and overflow on the same edge.
  - CAPTURE --eof sampled high--> DONE.
  - CAPTURE --valid while count==DEPTH--> ERROR.
  - start while in CAPTURE restarts the capture: count=0, state stays CAPTURE.
- ready is combinational: (state==CAPTURE) && (count<DEPTH). It never depends on valid.
- Write: on valid&&ready, RAM[count[ADDR_WIDTH-1:0]] <= data_in and count increments. No gaps; back-to-back words are accepted every cycle.
- valid&&eof in the same cycle: the word is written first (if ready), then the state moves to DONE. count includes that word.
- Full and eof in the same cycle: eof wins → DONE. The word is dropped and overflow stays 0.
- Full with valid and no eof: word dropped, overflow=1, ERROR. Held until start or reset.
- Words and eof presented in IDLE, DONE or ERROR are ignored (ready=0). count and flags are unchanged.
- count saturates at DEPTH and never wraps.
- Readback:
  - Read latency is 1 cycle. rd_en at edge N gives rd_data/rd_valid at edge N+1.
  - rd_valid is a 1-cycle pulse per rd_en.
  - Reads are allowed in any state.
  - rd_addr ≥ count gives rd_data=0 with rd_valid=1.
- Read and write to the same address in the same cycle: read-first, so the old contents are returned.
- Reset mid-capture: returns to IDLE immediately (asynchronous) and any in-flight read is aborted (rd_valid=0). Words already written stay in RAM but count=0.

Decomposition:
- Shared package file_sink_pkg:
  - state enum (IDLE, CAPTURE, DONE, ERROR)
  - default width constants ADDR_WIDTH_D=12, DATA_WIDTH_D=64, DEPTH_D=4096, shared with the file ROM
- Sub-module sink_ram: simple dual-port RAM (1 write, 1 registered read, read-first). It has no reset, to allow block-RAM inference.
- FSM, counter, handshake and flags live in the top level.

Test Plan:
- Sequence 65,66,66,65,66,66,66,65,66,66,65 sent on consecutive cycles after start, eof one cycle after the last word → count=11, done=1, busy=0, overflow=0. Readback of addr 0..10 returns the same values; addr 11 returns 0 with rd_valid=1.
- valid=1 and eof=1 on the last word (0x1234) in the same cycle → word stored, count=1, DONE next cycle, ready=0.
- DEPTH=4: five words sent → first four stored, ready=0 once count=4, fifth word gives overflow=1 and ERROR. Start then clears overflow and count=0.
- Words sent with valid=1 before any start → ready=0, count stays 0, RAM untouched. rst_n pulled low mid-capture at count=5 → count=0, IDLE, rd_valid=0 asynchronously.
- Read of addr 2 in the same cycle as a write of 0xAA to addr 2 → rd_data returns the prior value. A read one cycle later returns 0xAA.
- Capture of 3 words to DONE, then start and capture of 2 words (7,8) → count=2. Readback of addr 0..1 = 7,8; addr 2 returns 0 (≥count).
